// File: rtl/data_mem_pkg.sv
// ============================================================================
// Module  : data_mem_pkg
// Brief   : Access-type codes and memory-map constants shared by the data
//           memory, its load extender and the controller.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_mem_pkg;

   localparam int unsigned DM_WIDTH = 3;

   localparam logic [DM_WIDTH-1:0] DM_W  = 3'd0;
   localparam logic [DM_WIDTH-1:0] DM_H  = 3'd1;
   localparam logic [DM_WIDTH-1:0] DM_HU = 3'd2;
   localparam logic [DM_WIDTH-1:0] DM_B  = 3'd3;
   localparam logic [DM_WIDTH-1:0] DM_BU = 3'd4;

   localparam logic [31:0] DM_BASE = 32'h0000_0000;

   localparam int unsigned DM_DEPTH_DEFAULT = 3072;
   localparam int unsigned DM_AW_DEFAULT    = 12;

   // Codes 5..7 are not memory operations: loads yield 0, stores are dropped.
   function automatic logic dm_op_valid(input logic [DM_WIDTH-1:0] op);
      return (op <= DM_BU);
   endfunction

endpackage : data_mem_pkg

`default_nettype wire

// File: rtl/data_mem_ext.sv
// ============================================================================
// Module  : dm_ext
// Brief   : Selects the byte/half/word lane of a memory word and sign- or
//           zero-extends it to 32 bits for write-back.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_ext
   import data_mem_pkg::*;
(
   input  logic [31:0]         word,
   input  logic [1:0]          lane,
   input  logic [DM_WIDTH-1:0] mem_op,
   output logic [31:0]         ext
);

   logic [15:0] w_half;
   logic [7:0]  w_byte;

   // A half is addressed by lane[1] only; odd lanes are rejected upstream.
   assign w_half = lane[1] ? word[31:16] : word[15:0];

   always_comb begin
      w_byte = word[7:0];
      case (lane)
         2'd0:    w_byte = word[7:0];
         2'd1:    w_byte = word[15:8];
         2'd2:    w_byte = word[23:16];
         default: w_byte = word[31:24];
      endcase
   end

   always_comb begin
      ext = 32'd0;
      case (mem_op)
         DM_W:    ext = word;
         DM_H:    ext = {{16{w_half[15]}}, w_half};
         DM_HU:   ext = {16'd0, w_half};
         DM_B:    ext = {{24{w_byte[7]}}, w_byte};
         DM_BU:   ext = {24'd0, w_byte};
         default: ext = 32'd0;
      endcase
   end

endmodule : dm_ext

`default_nettype wire

// File: rtl/data_mem.sv
// ============================================================================
// Module  : data_mem
// Brief   : Word-organised data memory with byte/half/word loads and stores,
//           alignment/range checking and a registered store-commit record.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem
   import data_mem_pkg::*;
#(
   parameter int unsigned DEPTH = DM_DEPTH_DEFAULT,
   parameter int unsigned AW    = DM_AW_DEFAULT
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [31:0]         pc,
   input  logic [31:0]         addr,
   input  logic [DM_WIDTH-1:0] memOp,
   input  logic                wrEn,
   input  logic [31:0]         wrData,
   output logic [31:0]         rdData,
   output logic                memErr,
   output logic                logValid,
   output logic [31:0]         logPc,
   output logic [31:0]         logAddr,
   output logic [31:0]         logData
);

   localparam logic [31:0] c_byte_limit = 32'(DEPTH * 4);

   logic [31:0]   r_mem [DEPTH];

   logic [AW-1:0] w_word_idx;
   logic [AW-1:0] w_safe_idx;
   logic [1:0]    w_lane;
   logic          w_in_range;
   logic          w_misalign;
   logic          w_commit;
   logic [31:0]   w_rd_word;
   logic [31:0]   w_ext;
   logic [31:0]   w_merged;

   assign w_word_idx = addr[AW+1:2];
   assign w_lane     = addr[1:0];

   // Full 32-bit compare so high address bits can never alias into the array.
   assign w_in_range = (addr < c_byte_limit);

   always_comb begin
      w_misalign = 1'b0;
      case (memOp)
         DM_W:        w_misalign = (w_lane != 2'd0);
         DM_H, DM_HU: w_misalign = w_lane[0];
         default:     w_misalign = 1'b0;
      endcase
   end

   assign memErr     = w_misalign | ~w_in_range;
   assign w_safe_idx = w_in_range ? w_word_idx : '0;
   assign w_rd_word  = r_mem[w_safe_idx];
   assign w_commit   = wrEn & ~memErr & dm_op_valid(memOp);

   dm_ext u_ext (
      .word   (w_rd_word),
      .lane   (w_lane),
      .mem_op (memOp),
      .ext    (w_ext)
   );

   assign rdData = memErr ? 32'd0 : w_ext;

   always_comb begin
      w_merged = w_rd_word;
      case (memOp)
         DM_W: w_merged = wrData;
         DM_H, DM_HU: begin
            if (w_lane[1]) w_merged[31:16] = wrData[15:0];
            else           w_merged[15:0]  = wrData[15:0];
         end
         DM_B, DM_BU: begin
            case (w_lane)
               2'd0:    w_merged[7:0]   = wrData[7:0];
               2'd1:    w_merged[15:8]  = wrData[7:0];
               2'd2:    w_merged[23:16] = wrData[7:0];
               default: w_merged[31:24] = wrData[7:0];
            endcase
         end
         default: w_merged = w_rd_word;
      endcase
   end

   // Reset wins over a simultaneous store and clears the whole array.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= 32'd0;
         end
         logValid <= 1'b0;
         logPc    <= 32'd0;
         logAddr  <= 32'd0;
         logData  <= 32'd0;
      end else begin
         logValid <= w_commit;
         if (w_commit) begin
            r_mem[w_safe_idx] <= w_merged;
            logPc             <= pc;
            logAddr           <= {addr[31:2], 2'b00};
            logData           <= w_merged;
         end
      end
   end

endmodule : data_mem

`default_nettype wire

// File: doc/data_mem.md
Name: data_mem

Overview:
- Word-organised data memory for the single-cycle MIPS datapath. Sits directly downstream of the ALU.
- Consumes the ALU result as the byte address and GRF rt data as store data.
- Returns sign- or zero-extended load data to the GRF write-back mux.
- Supports lw/lh/lhu/lb/lbu and sw/sh/sb, flags misaligned or out-of-range accesses, and emits a registered write-commit record for the bench.

Parameters:
- DEPTH, 3072, number of 32-bit words; valid byte range is 0 to DEPTH*4-1 (0x0000–0x2FFF at default).
- AW, 12, word-index width; must satisfy 2^AW >= DEPTH.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- pc  in  32  PC of the current instruction; used only for the commit record.
- addr  in  32  byte address, taken from the ALU result.
- memOp  in  3  access type, encoded with the DM_* codes.
- wrEn  in  1  store enable from the controller.
- wrData  in  32  store data (rt value); the low byte or low half is used for sb/sh.
- rdData  out  32  extended load data.
- memErr  out  1  current access is misaligned or out of range.
- logValid  out  1  a store committed on the previous edge.
- logPc  out  32  PC of the committed store.
- logAddr  out  32  word-aligned byte address of the committed store.
- logData  out  32  full merged word after the committed store.

Behaviour:
- Reset: on a rising edge with rst_n=0, all DEPTH words become 0. logValid, logPc, logAddr and logData become 0. No store commits in that cycle, even if wrEn=1.
- Read path is combinational; load data is valid in the same cycle addr and memOp are valid.
  - Word index = addr[AW+1:2]; lane = addr[1:0].
  - DM_W: full word.
  - DM_H: lane 0 or 2 selects the half; sign-extend to 32 bits.
  - DM_HU: same half selection; zero-extend.
  - DM_B: byte at lane; sign-extend.
  - DM_BU: byte at lane; zero-extend.
- Write path is synchronous. At the rising edge with rst_n=1, wrEn=1 and memErr=0, the selected word is updated:
  - DM_W replaces the whole word.
  - DM_H/DM_HU replace bytes lane+1..lane with wrData[15:0].
  - DM_B/DM_BU replace the lane byte with wrData[7:0].
  - Untouched bytes keep their old value.
- Alignment error, memErr=1:
  - DM_W with addr[1:0]≠0.
  - DM_H/DM_HU with addr[0]=1.
- Range error, memErr=1: addr >= DEPTH*4, checked over all 32 bits, with no aliasing.
- When memErr=1:
  - any store is suppressed;
  - rdData=0;
  - logValid=0 on the next cycle.
- memErr is also evaluated when wrEn=0, but the controller uses it only for memory instructions.
- Read-during-write at the same address: rdData shows the old contents in that cycle and the new contents from the next cycle on. There is no bypass.
- Commit record: on the edge that performs a store, the following are registered and held for exactly one cycle:
  - logValid=1;
  - logPc=pc;
  - logAddr={addr[31:2],2'b00};
  - logData=merged word.
- logValid returns to 0 on the following edge unless another store commits. Back-to-back stores give logValid high on consecutive cycles.
- Undefined memOp codes (5–7): loads return 0 and stores are suppressed. memErr stays 0.
- Reset asserted mid-stream overrides a simultaneous store. Memory reads as 0 on the cycle after the reset edge.

Decomposition:
- Shared macro include holds:
  - DM_W=0, DM_H=1, DM_HU=2, DM_B=3, DM_BU=4;
  - DM_BASE=32'h0000_0000;
  - the default DEPTH.
- The controller and the datapath top both reference these codes.
- One natural sub-module: dm_ext, purely combinational. Inputs are the 32-bit word, lane and memOp; output is the extended load data.
- The byte-merge logic for stores stays inline in data_mem.

Test Plan:
- Reset with memory preloaded, rst_n=0 for one edge → all reads 0, logValid=0. Asserting wrEn during reset does not write.
- sw addr=0x10 data=0x8899AABB → next edge: logValid=1, logAddr=0x10, logData=0x8899AABB. Same cycle as the write, lw 0x10 still reads the old value 0; next cycle it reads 0x8899AABB.
- With word 0x10=0x8899AABB:
  - lb 0x13 → 0xFFFFFF88; lbu 0x13 → 0x00000088; lh 0x10 → 0xFFFFAABB; lhu 0x12 → 0x00008899.
  - sb 0x11 data=0x123 → logData=0x8899_23BB.
- Misaligned: sw 0x12 → memErr=1, no write, logValid stays 0. lh 0x11 → memErr=1, rdData=0.
- Out of range: sw 0x3000 and lw 0xFFFF_FFFC → memErr=1, no write. sw 0x2FFC data=0x1 → commits normally, logAddr=0x2FFC.
- Back-to-back: sh 0x20 data=0xBEEF, then sh 0x22 data=0xDEAD on consecutive cycles → logValid high two cycles, logData 0x0000BEEF then 0xDEADBEEF.
